// File: rtl/dram_req_seq_pkg.sv
// Shared types and constants for the DDR2 request sequencer and its
// read-return collector.
package dram_req_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WDATA = 2'd1,
      ADDR  = 2'd2
   } seq_state_t;

   localparam int DEF_ADDR_W      = 28;
   localparam int DEF_BEAT_W      = 144;
   localparam int DEF_BEATS       = 2;
   localparam int DEF_MAX_RD      = 4;
   localparam int DEF_WDOG_CYCLES = 4096;

   // Outstanding-read counter; 4 bits covers MAX_RD up to 15.
   localparam int CNT_W  = 4;
   localparam int WDOG_W = 16;

   // Width of a beat index for a line of 'beats' beats (at least one bit).
   function automatic int beat_idx_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/dram_rsp_collector.sv
// Read-return path: pops beats from the controller read buffer, assembles
// them into a whole line and presents it on the rsp valid/ready handshake.
// rsp_fire pulses for one cycle on each accepted response.
import dram_req_seq_pkg::*;

module dram_rsp_collector #(
   parameter int BEAT_W = DEF_BEAT_W,
   parameter int BEATS  = DEF_BEATS
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [BEAT_W-1:0]       rb_data,
   input  logic                    rb_empty,
   output logic                    rb_read,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [BEATS*BEAT_W-1:0] rsp_rdata,
   output logic                    rsp_fire
);

   localparam int BIDX_W = beat_idx_w(BEATS);
   localparam int LINE_W = BEATS*BEAT_W;

   logic [BIDX_W-1:0] rcv_idx_q, rcv_idx_d;
   logic              line_full_q, line_full_d;
   logic [LINE_W-1:0] line_q, line_d;

   // Pop while the line buffer has room; a full line blocks further pops
   // until the client takes it, so rsp_ready never reaches rb_read.
   always_comb begin
      rcv_idx_d   = rcv_idx_q;
      line_full_d = line_full_q;
      line_d      = line_q;
      rb_read     = !rb_empty && !line_full_q;
      rsp_valid   = line_full_q;
      rsp_fire    = line_full_q && rsp_ready;
      if (rb_read) begin
         line_d[rcv_idx_q*BEAT_W +: BEAT_W] = rb_data;
         if (rcv_idx_q == BIDX_W'(BEATS-1)) begin
            rcv_idx_d   = '0;
            line_full_d = 1'b1;
         end else begin
            rcv_idx_d = rcv_idx_q + 1'b1;
         end
      end
      if (rsp_fire) begin
         line_full_d = 1'b0;
      end
   end

   // Collector state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rcv_idx_q   <= '0;
         line_full_q <= 1'b0;
         line_q      <= '0;
      end else begin
         rcv_idx_q   <= rcv_idx_d;
         line_full_q <= line_full_d;
         line_q      <= line_d;
      end
   end

   assign rsp_rdata = line_q;

endmodule

// File: rtl/dram_req_sequencer.sv
// Line-granular client to BEE3 DDR2 FIFO user interface adapter.
// Writes: all beats into WB, then one AF command. Reads: one AF command,
// bounded by an outstanding-read credit count.
// Optional build macro DRAM_REQ_SEQ_WDOG_EN adds a sticky stalled-read
// watchdog; without it wdog_err is tied low.
//
// state | meaning
// IDLE  | ready for a new line request (when read credits remain)
// WDATA | pushing latched write beats into the write buffer
// ADDR  | issuing the address-FIFO command for the latched request
import dram_req_seq_pkg::*;

module dram_req_sequencer #(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int BEAT_W      = DEF_BEAT_W,
   parameter int BEATS       = DEF_BEATS,
   parameter int MAX_RD      = DEF_MAX_RD,
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_read,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [BEATS*BEAT_W-1:0] req_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [BEATS*BEAT_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0]       af_addr,
   output logic                    af_read,
   output logic                    af_write,
   input  logic                    af_full,
   output logic [BEAT_W-1:0]       wb_data,
   output logic                    wb_write,
   input  logic                    wb_full,
   input  logic [BEAT_W-1:0]       rb_data,
   output logic                    rb_read,
   input  logic                    rb_empty,
   output logic                    wdog_err
);

   localparam int BIDX_W = beat_idx_w(BEATS);
   localparam int LINE_W = BEATS*BEAT_W;

   seq_state_t        state_q, state_d;
   logic [BIDX_W-1:0] beat_idx_q, beat_idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              read_q, read_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic              rsp_fire;
   logic              rd_issue;

   // Next-state and strobe decode; strobes depend only on state and FIFO flags.
   always_comb begin
      state_d    = state_q;
      beat_idx_d = beat_idx_q;
      addr_d     = addr_q;
      read_d     = read_q;
      wdata_d    = wdata_q;
      req_ready  = 1'b0;
      wb_write   = 1'b0;
      af_write   = 1'b0;
      af_read    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = (rd_cnt_q < CNT_W'(MAX_RD));
            if (req_valid && req_ready) begin
               addr_d     = req_addr;
               read_d     = req_read;
               wdata_d    = req_wdata;
               beat_idx_d = '0;
               state_d    = req_read ? ADDR : WDATA;
            end
         end
         WDATA: begin
            wb_write = !wb_full;
            if (wb_write) begin
               if (beat_idx_q == BIDX_W'(BEATS-1)) begin
                  state_d = ADDR;
               end else begin
                  beat_idx_d = beat_idx_q + 1'b1;
               end
            end
         end
         ADDR: begin
            af_write = !af_full;
            af_read  = read_q;
            if (af_write) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wb_data  = wdata_q[beat_idx_q*BEAT_W +: BEAT_W];
   assign af_addr  = addr_q;
   assign rd_issue = af_write && af_read;

   // Outstanding-read credits: issue and return in the same cycle cancel.
   always_comb begin
      rd_cnt_d = rd_cnt_q;
      if (rd_issue && !rsp_fire) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
      end else if (!rd_issue && rsp_fire) begin
         rd_cnt_d = rd_cnt_q - 1'b1;
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         beat_idx_q <= '0;
         addr_q     <= '0;
         read_q     <= 1'b0;
         wdata_q    <= '0;
         rd_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         beat_idx_q <= beat_idx_d;
         addr_q     <= addr_d;
         read_q     <= read_d;
         wdata_q    <= wdata_d;
         rd_cnt_q   <= rd_cnt_d;
      end
   end

   dram_rsp_collector #(
      .BEAT_W (BEAT_W),
      .BEATS  (BEATS)
   ) u_rsp_collector (
      .clk       (clk),
      .rstn      (rstn),
      .rb_data   (rb_data),
      .rb_empty  (rb_empty),
      .rb_read   (rb_read),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_fire  (rsp_fire)
   );

`ifdef DRAM_REQ_SEQ_WDOG_EN
   logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
   logic              wdog_err_q, wdog_err_d;

   // Count cycles with reads outstanding but no beat returning; latch on limit.
   always_comb begin
      wdog_cnt_d = wdog_cnt_q;
      wdog_err_d = wdog_err_q;
      if ((rd_cnt_q == '0) || rb_read) begin
         wdog_cnt_d = '0;
      end else if (wdog_cnt_q != '1) begin
         wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
      if (wdog_cnt_d == WDOG_W'(WDOG_CYCLES)) begin
         wdog_err_d = 1'b1;
      end
   end

   // Watchdog registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wdog_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
         wdog_err_q <= wdog_err_d;
      end
   end

   assign wdog_err = wdog_err_q;
`else
   assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_req_sequencer.sv
// Testbench for dram_req_sequencer: acts as the DDR2 controller (WB/AF/RB
// FIFOs) and the line client, checking against a transaction-level model.
module tb_dram_req_sequencer;

   localparam int ADDR_W = 28;
   localparam int BEAT_W = 144;
   localparam int BEATS  = 2;
   localparam int MAX_RD = 4;
   localparam int WDOG   = 16;
   localparam int LINE_W = BEATS*BEAT_W;
`ifdef DRAM_REQ_SEQ_WDOG_EN
   localparam bit WD_EXP = 1'b1;
`else
   localparam bit WD_EXP = 1'b0;
`endif

   typedef logic [BEAT_W-1:0] beat_t;
   typedef logic [LINE_W-1:0] line_t;
   typedef struct {
      logic              rd;
      logic [ADDR_W-1:0] addr;
      line_t             data;
   } req_t;

   logic              clk = 1'b0;
   logic              rstn;
   logic              req_valid, req_ready, req_read;
   logic [ADDR_W-1:0] req_addr;
   line_t             req_wdata;
   logic              rsp_valid, rsp_ready;
   line_t             rsp_rdata;
   logic [ADDR_W-1:0] af_addr;
   logic              af_read, af_write, af_full;
   beat_t             wb_data;
   logic              wb_write, wb_full;
   beat_t             rb_data;
   logic              rb_read, rb_empty;
   logic              wdog_err;

   always #5 clk = ~clk;

   dram_req_sequencer #(
      .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS),
      .MAX_RD(MAX_RD), .WDOG_CYCLES(WDOG)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .af_addr(af_addr), .af_read(af_read), .af_write(af_write), .af_full(af_full),
      .wb_data(wb_data), .wb_write(wb_write), .wb_full(wb_full),
      .rb_data(rb_data), .rb_read(rb_read), .rb_empty(rb_empty),
      .wdog_err(wdog_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input line_t got, input line_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Controller / client model
   req_t  pend[$];
   beat_t wbq[$];
   beat_t rbq[$];
   line_t exp_rsp[$];
   int    outstanding;
   int    coll_n;
   bit    rb_hold;
   int    rb_stall_pct;

   // Per-cycle snapshots of DUT outputs
   bit                s_acc, s_req_ready, s_wb_write, s_af_write, s_af_read;
   bit                s_rb_read, s_rsp_valid, s_rsp_fire, s_wdog;
   beat_t             s_wb_data;
   logic [ADDR_W-1:0] s_af_addr;
   line_t             s_rsp_rdata;

   function automatic beat_t rnd_beat();
      logic [159:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return w[BEAT_W-1:0];
   endfunction

   function automatic line_t rnd_line();
      line_t l;
      for (int i = 0; i < BEATS; i++) l[i*BEAT_W +: BEAT_W] = rnd_beat();
      return l;
   endfunction

   function automatic logic [ADDR_W-1:0] rnd_addr();
      logic [31:0] t;
      t = $urandom;
      return t[ADDR_W-1:0];
   endfunction

   task automatic model_reset();
      pend.delete();
      wbq.delete();
      rbq.delete();
      exp_rsp.delete();
      outstanding = 0;
      coll_n      = 0;
   endtask

   task automatic drive_ctrl();
      if (rb_hold || rbq.size() == 0 || ($urandom_range(99) < rb_stall_pct)) begin
         rb_empty = 1'b1;
         rb_data  = rnd_beat();
      end else begin
         rb_empty = 1'b0;
         rb_data  = rbq[0];
      end
   endtask

   task automatic mon();
      req_t  r;
      line_t l;
      s_acc       = req_valid && req_ready;
      s_req_ready = req_ready;
      s_wb_write  = wb_write;
      s_wb_data   = wb_data;
      s_af_write  = af_write;
      s_af_read   = af_read;
      s_af_addr   = af_addr;
      s_rb_read   = rb_read;
      s_rsp_valid = rsp_valid;
      s_rsp_fire  = rsp_valid && rsp_ready;
      s_rsp_rdata = rsp_rdata;
      s_wdog      = wdog_err;

      chk("req_ready", req_ready, (pend.size() == 0) && (outstanding < MAX_RD));
      chk("rsp_valid", rsp_valid, coll_n == BEATS);
      chk("rb_read", rb_read, !rb_empty && (coll_n < BEATS));

      if (req_valid && req_ready) begin
         r.rd   = req_read;
         r.addr = req_addr;
         r.data = req_wdata;
         pend.push_back(r);
      end
      if (wb_write) begin
         chk("wb_write_while_full", wb_full, 0);
         wbq.push_back(wb_data);
      end
      if (af_write) begin
         chk("af_write_while_full", af_full, 0);
         chk("af_has_request", pend.size() > 0, 1);
         if (pend.size() > 0) begin
            r = pend.pop_front();
            chk("af_read", af_read, r.rd);
            chk("af_addr", af_addr, r.addr);
            if (!r.rd) begin
               chk("wb_beats_before_cmd", wbq.size(), BEATS);
               for (int i = 0; i < BEATS; i++)
                  if (wbq.size() > 0) chk("wb_beat", wbq.pop_front(), r.data[i*BEAT_W +: BEAT_W]);
               wbq.delete();
            end else begin
               l = '0;
               for (int i = 0; i < BEATS; i++) begin
                  l[i*BEAT_W +: BEAT_W] = rnd_beat();
                  rbq.push_back(l[i*BEAT_W +: BEAT_W]);
               end
               exp_rsp.push_back(l);
               outstanding++;
            end
         end
      end
      if (rsp_valid && rsp_ready) begin
         chk("rsp_pending", exp_rsp.size() > 0, 1);
         if (exp_rsp.size() > 0) begin
            chk("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
            outstanding--;
         end
         coll_n = 0;
      end
      if (rb_read && !rb_empty) begin
         void'(rbq.pop_front());
         coll_n++;
      end
   endtask

   // One clock cycle: controller flags at negedge, observe, return after posedge.
   task automatic step();
      @(negedge clk);
      drive_ctrl();
      #1;
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      req_valid    = 1'b0;
      rsp_ready    = 1'b0;
      wb_full      = 1'b0;
      af_full      = 1'b0;
      rb_hold      = 1'b0;
      rb_stall_pct = 0;
   endtask

   task automatic issue(input bit rd);
      req_read  = rd;
      req_addr  = rnd_addr();
      req_wdata = rnd_line();
      req_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         if (s_acc) break;
      end
      chk("accept_timeout", s_acc, 1);
      req_valid = 1'b0;
   endtask

   task automatic wait_af();
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (s_af_write) begin
            seen = 1;
            break;
         end
      end
      chk("af_timeout", seen, 1);
   endtask

   task automatic wait_rsp_valid();
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (s_rsp_valid) begin
            seen = 1;
            break;
         end
      end
      chk("rsp_valid_timeout", seen, 1);
   endtask

   task automatic drain();
      bit done = 0;
      set_idle();
      rsp_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (pend.size() == 0 && outstanding == 0 && rbq.size() == 0 && coll_n == 0) begin
            done = 1;
            break;
         end
         step();
      end
      chk("drain_timeout", done, 1);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      beat_t a, b;
      line_t held;
      int    cnt;

      rstn      = 1'b0;
      set_idle();
      rb_hold   = 1'b1;
      req_read  = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rb_data   = '0;
      rb_empty  = 1'b1;
      model_reset();
      repeat (3) step();
      chk("rst_req_ready", s_req_ready, 1);
      chk("rst_wb_write", s_wb_write, 0);
      chk("rst_af_write", s_af_write, 0);
      chk("rst_rsp_valid", s_rsp_valid, 0);
      rstn    = 1'b1;
      rb_hold = 1'b0;
      step();

      // Write, no backpressure: beats in cycles 1-2, command in cycle 3
      a = rnd_beat();
      b = rnd_beat();
      req_read  = 1'b0;
      req_addr  = 28'h0000123;
      req_wdata = {b, a};
      req_valid = 1'b1;
      step();
      chk("t1_accept", s_acc, 1);
      req_valid = 1'b0;
      step();
      chk("t1_c1_wb_write", s_wb_write, 1);
      chk("t1_c1_wb_data", s_wb_data, a);
      step();
      chk("t1_c2_wb_write", s_wb_write, 1);
      chk("t1_c2_wb_data", s_wb_data, b);
      step();
      chk("t1_c3_af_write", s_af_write, 1);
      chk("t1_c3_af_read", s_af_read, 0);
      chk("t1_c3_af_addr", s_af_addr, 28'h0000123);
      step();
      chk("t1_c4_req_ready", s_req_ready, 1);

      // wb_full in cycle 2 only: beat B slips to cycle 3, command to cycle 4
      a = rnd_beat();
      b = rnd_beat();
      req_addr  = rnd_addr();
      req_wdata = {b, a};
      req_valid = 1'b1;
      step();
      chk("t2_accept", s_acc, 1);
      req_valid = 1'b0;
      step();
      chk("t2_c1_wb_data", s_wb_data, a);
      wb_full = 1'b1;
      step();
      chk("t2_c2_stall", s_wb_write, 0);
      wb_full = 1'b0;
      step();
      chk("t2_c3_wb_write", s_wb_write, 1);
      chk("t2_c3_wb_data", s_wb_data, b);
      step();
      chk("t2_c4_af_write", s_af_write, 1);

      // Credit limit: four reads exhaust credits, one response restores one
      rb_hold = 1'b1;
      for (int k = 0; k < MAX_RD; k++) begin
         issue(1'b1);
         wait_af();
      end
      step();
      chk("t3_no_credit", s_req_ready, 0);
      rb_hold   = 1'b0;
      rsp_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (s_rsp_fire) begin
            cnt = 1;
            break;
         end
      end
      chk("t3_rsp_timeout", cnt, 1);
      rsp_ready = 1'b0;
      rb_hold   = 1'b1;
      step();
      chk("t3_credit_back", s_req_ready, 1);
      drain();

      // Full line held while client stalls; next line's beats stay in RB
      rb_hold = 1'b1;
      issue(1'b1);
      wait_af();
      issue(1'b1);
      wait_af();
      rb_hold = 1'b0;
      wait_rsp_valid();
      held = s_rsp_rdata;
      chk("t4_line", held, exp_rsp[0]);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_rsp_valid_held", s_rsp_valid, 1);
         chk("t4_rb_read_blocked", s_rb_read, 0);
         chk("t4_rdata_stable", s_rsp_rdata, held);
      end
      drain();

      // Read command and response handshake in the same cycle
      rb_hold = 1'b1;
      issue(1'b1);
      wait_af();
      issue(1'b1);
      wait_af();
      rb_hold = 1'b0;
      wait_rsp_valid();
      af_full = 1'b1;
      issue(1'b1);
      step();
      af_full   = 1'b0;
      rsp_ready = 1'b1;
      step();
      chk("t5_af_write", s_af_write, 1);
      chk("t5_rsp_fire", s_rsp_fire, 1);
      rsp_ready = 1'b0;
      rb_hold   = 1'b1;
      req_read  = 1'b1;
      req_addr  = rnd_addr();
      req_valid = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (s_acc) cnt++;
      end
      req_valid = 1'b0;
      chk("t5_accepts_left", cnt, MAX_RD - 2);
      drain();

      // Stalled read and the watchdog
      rb_hold = 1'b1;
      issue(1'b1);
      wait_af();
      repeat (10) step();
      chk("wdog_early", s_wdog, 0);
      repeat (10) step();
      chk("wdog_late", s_wdog, WD_EXP);

      // Async reset in the middle of a write line
      issue(1'b0);
      step();
      rstn = 1'b0;
      #2;
      chk("rst_mid_req_ready", req_ready, 1);
      chk("rst_mid_wb_write", wb_write, 0);
      chk("rst_mid_wb_data", wb_data, 0);
      chk("rst_mid_af_write", af_write, 0);
      chk("rst_mid_af_read", af_read, 0);
      chk("rst_mid_af_addr", af_addr, 0);
      chk("rst_mid_rb_read", rb_read, 0);
      chk("rst_mid_rsp_valid", rsp_valid, 0);
      chk("rst_mid_rsp_rdata", rsp_rdata, 0);
      chk("rst_mid_wdog_err", wdog_err, 0);
      model_reset();
      repeat (2) step();
      rstn    = 1'b1;
      rb_hold = 1'b0;
      step();
      chk("rst_mid_ready_after", s_req_ready, 1);

      // Randomized traffic with backpressure everywhere
      rb_stall_pct = 30;
      for (int i = 0; i < 800; i++) begin
         if (!req_valid && $urandom_range(99) < 40) begin
            req_read  = $urandom_range(1);
            req_addr  = rnd_addr();
            req_wdata = rnd_line();
            req_valid = 1'b1;
         end
         wb_full   = ($urandom_range(99) < 25);
         af_full   = ($urandom_range(99) < 25);
         rsp_ready = ($urandom_range(99) < 60);
         step();
         if (s_acc) req_valid = 1'b0;
      end
      drain();
      chk("final_no_pending", pend.size() + exp_rsp.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
